// File: rtl/sar_adc_pkg.sv
`default_nettype none
// ============================================================================
// Module : sar_adc_pkg
// Brief  : Shared state encoding and default geometry for the SAR ADC controller.
// Rev    : 1.0
// ============================================================================
package sar_adc_pkg;

  localparam int unsigned c_default_width         = 10;
  localparam int unsigned c_default_sample_cycles = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2
  } sar_state_t;

endpackage
`default_nettype wire

// File: rtl/sar_register.sv
`default_nettype none
// ============================================================================
// Module : sar_register
// Brief  : Successive-approximation trial-code register and bit-index tracker.
// Rev    : 1.0
// ============================================================================
module sar_register
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             comp,
  output logic [WIDTH-1:0] code,
  output logic [WIDTH-1:0] result,
  output logic             last
);

  localparam int unsigned      IDX_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] c_msb_idx = IDX_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_code;
  logic [WIDTH-1:0] w_code_next;
  logic [WIDTH-1:0] w_decided;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_next;

  // The bit under trial takes the comparator verdict; everything above it is settled.
  always_comb begin
    w_decided        = r_code;
    w_decided[r_idx] = comp;
  end

  always_comb begin
    w_code_next = r_code;
    w_idx_next  = r_idx;
    if (init) begin
      w_code_next            = '0;
      w_code_next[WIDTH-1]   = 1'b1;
      w_idx_next             = c_msb_idx;
    end else if (step) begin
      if (r_idx == '0) begin
        // Final decision taken: park the DAC at zero for the idle period.
        w_code_next = '0;
        w_idx_next  = c_msb_idx;
      end else begin
        w_code_next                = w_decided;
        w_code_next[r_idx - 1'b1]  = 1'b1;
        w_idx_next                 = r_idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_code <= '0;
      r_idx  <= c_msb_idx;
    end else begin
      r_code <= w_code_next;
      r_idx  <= w_idx_next;
    end
  end

  assign code   = r_code;
  assign result = w_decided;
  assign last   = (r_idx == '0);

endmodule
`default_nettype wire

// File: rtl/sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : sar_adc_ctrl
// Brief  : SAR ADC controller: track/hold, binary search via DAC + comparator, valid/ready result.
// Rev    : 1.0
// ============================================================================
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int unsigned WIDTH         = c_default_width,
  parameter int unsigned SAMPLE_CYCLES = c_default_sample_cycles
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             start,
  input  logic             COMP,
  output logic             SAMPLE,
  output logic [WIDTH-1:0] DAC_D,
  output logic             busy,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun
);

  localparam int unsigned      CNT_W      = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SAMPLE_CYCLES - 1);

  sar_state_t       r_state;
  sar_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_sar_init;
  logic             w_sar_step;
  logic             w_sar_last;
  logic             w_done;
  logic [WIDTH-1:0] w_sar_code;
  logic [WIDTH-1:0] w_sar_result;
  logic [WIDTH-1:0] r_data;
  logic             r_data_valid;
  logic             r_overrun;

  sar_register #(
    .WIDTH (WIDTH)
  ) u_sar_register (
    .clk    (CLK),
    .rst    (reset),
    .init   (w_sar_init),
    .step   (w_sar_step),
    .comp   (COMP),
    .code   (w_sar_code),
    .result (w_sar_result),
    .last   (w_sar_last)
  );

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // start is only looked at in IDLE, so requests during a conversion are dropped.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sar_init   = 1'b0;
    w_sar_step   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SAMPLE;
          w_cnt_next   = '0;
        end
      end
      ST_SAMPLE: begin
        if (r_cnt == c_cnt_last) begin
          w_state_next = ST_CONVERT;
          w_cnt_next   = '0;
          w_sar_init   = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_CONVERT: begin
        w_sar_step = 1'b1;
        if (w_sar_last) begin
          w_done       = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // A fresh result always wins; it only counts as lost if the old one was never taken.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_done) begin
        r_data       <= w_sar_result;
        r_data_valid <= 1'b1;
        if (r_data_valid && !data_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_data_valid && data_ready) begin
        r_data_valid <= 1'b0;
      end
    end
  end

  assign SAMPLE     = (r_state == ST_SAMPLE);
  assign busy       = (r_state != ST_IDLE);
  assign DAC_D      = w_sar_code;
  assign data       = r_data;
  assign data_valid = r_data_valid;
  assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sar_adc_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_sar_adc_ctrl
// Brief  : Self-checking bench for sar_adc_ctrl against an ideal binary-search model.
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_sar_adc_ctrl;

  localparam int W      = 10;
  localparam int SC     = 4;
  localparam int LAT    = SC + W;
  localparam int PERIOD = SC + W + 1;

  logic         CLK = 1'b0;
  logic         reset;
  logic         start;
  logic         COMP;
  logic         SAMPLE;
  logic [W-1:0] DAC_D;
  logic         busy;
  logic [W-1:0] data;
  logic         data_valid;
  logic         data_ready;
  logic         overrun;

  logic [W-1:0] vin;
  int           comp_mode;
  int           checks;
  int           errors;

  logic [W-1:0] obs_dac [W];
  int           obs_n;
  logic [W-1:0] exp_trial [W];
  logic [W-1:0] exp_res;

  always #5 CLK = ~CLK;

  // Ideal comparator: mode 0 follows the analog input, 1/2 tie high/low.
  assign COMP = (comp_mode == 1) ? 1'b1 : (comp_mode == 2) ? 1'b0 : (vin >= DAC_D);

  sar_adc_ctrl #(
    .WIDTH         (W),
    .SAMPLE_CYCLES (SC)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .start      (start),
    .COMP       (COMP),
    .SAMPLE     (SAMPLE),
    .DAC_D      (DAC_D),
    .busy       (busy),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overrun    (overrun)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Binary search as a sequence of guesses: try each bit from the top, keep it if Vin is not below.
  function automatic void model(input logic [W-1:0] v, input int mode);
    logic [W-1:0] acc;
    logic [W-1:0] trial;
    logic         keep;
    acc = '0;
    for (int b = W - 1; b >= 0; b--) begin
      trial = acc | (W'(1) << b);
      exp_trial[W-1-b] = trial;
      keep = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b0 : (v >= trial);
      if (keep) acc = trial;
    end
    exp_res = acc;
  endfunction

  // Pulse start, then record SAMPLE width, trial codes and cycles until busy falls.
  task automatic capture(input int ready_at, output int sample_hi, output int lat);
    sample_hi = 0;
    lat       = -1;
    obs_n     = 0;
    for (int i = 0; i < W; i++) obs_dac[i] = 'x;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 40; k++) begin
      if (!busy) begin
        lat = k;
        break;
      end
      if (SAMPLE) sample_hi++;
      if (!SAMPLE && obs_n < W) begin
        obs_dac[obs_n] = DAC_D;
        obs_n++;
      end
      if (ready_at >= 0) data_ready = (k == ready_at);
      tick();
    end
    if (ready_at >= 0) data_ready = 1'b0;
  endtask

  task automatic consume();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; data_ready = 1'b0; vin = '0; comp_mode = 0;
    tick(); tick();
    checks++; if (SAMPLE !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b expected 0", SAMPLE); end
    checks++; if (DAC_D !== '0) begin errors++; $display("FAIL reset_dac: got %h expected 000", DAC_D); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data: got %h expected 000", data); end
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    reset = 1'b0;
    tick(); tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_without_start: got busy %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int sh, lat;
    vin = 10'h2A5; comp_mode = 0;
    model(vin, 0);
    capture(-1, sh, lat);
    checks++; if (sh != SC) begin errors++; $display("FAIL basic_sample_width: got %0d expected %0d", sh, SC); end
    for (int i = 0; i < W; i++) begin
      checks++;
      if (obs_dac[i] !== exp_trial[i]) begin
        errors++; $display("FAIL basic_trial[%0d]: got %h expected %h", i, obs_dac[i], exp_trial[i]);
      end
    end
    checks++; if (lat != LAT) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LAT); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", data_valid); end
    checks++; if (data !== 10'h2A5) begin errors++; $display("FAIL basic_data: got %h expected 2a5", data); end
    checks++; if (DAC_D !== '0) begin errors++; $display("FAIL basic_dac_idle: got %h expected 000", DAC_D); end
    consume();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b expected 0", data_valid); end
  endtask

  task automatic test_extremes();
    int sh, lat;
    comp_mode = 1;
    capture(-1, sh, lat);
    checks++; if (sh != SC) begin errors++; $display("FAIL high_sample_width: got %0d expected %0d", sh, SC); end
    checks++; if (data !== 10'h3FF) begin errors++; $display("FAIL high_data: got %h expected 3ff", data); end
    consume();
    comp_mode = 2;
    capture(-1, sh, lat);
    checks++; if (sh != SC) begin errors++; $display("FAIL low_sample_width: got %0d expected %0d", sh, SC); end
    checks++; if (data !== 10'h000) begin errors++; $display("FAIL low_data: got %h expected 000", data); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL low_valid: got %b expected 1", data_valid); end
    consume();
    comp_mode = 0;
  endtask

  task automatic test_consume();
    int sh, lat;
    logic [W-1:0] v;
    v = W'($urandom_range(1, 1023));
    vin = v;
    capture(-1, sh, lat);
    checks++; if (data !== v) begin errors++; $display("FAIL consume_data: got %h expected %h", data, v); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (data_valid !== 1'b1 || data !== v) begin
        errors++; $display("FAIL consume_hold[%0d]: got valid %b data %h expected 1 %h", i, data_valid, data, v);
      end
    end
    data_ready = 1'b1;
    #1;
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL consume_before_edge: got %b expected 1", data_valid); end
    tick();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL consume_drop: got %b expected 0", data_valid); end
    checks++; if (data !== v) begin errors++; $display("FAIL consume_data_kept: got %h expected %h", data, v); end
  endtask

  task automatic test_overrun();
    int sh, lat;
    pulse_reset();
    data_ready = 1'b0;
    vin = 10'h155;
    capture(-1, sh, lat);
    checks++; if (data !== 10'h155 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_first: got data %h ovr %b expected 155 0", data, overrun);
    end
    vin = 10'h0AA;
    capture(-1, sh, lat);
    checks++; if (data !== 10'h0AA) begin errors++; $display("FAIL ovr_data: got %h expected 0aa", data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    consume();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    pulse_reset();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_reset_clear: got %b expected 0", overrun); end
    vin = 10'h155;
    capture(-1, sh, lat);
    vin = 10'h0AA;
    capture(LAT - 1, sh, lat);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ready_no_ovr: got %b expected 0", overrun); end
    checks++; if (data !== 10'h0AA) begin errors++; $display("FAIL ready_data: got %h expected 0aa", data); end
    checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL ready_valid_stays: got %b expected 1", data_valid); end
    consume();
    checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL ready_consumed: got %b expected 0", data_valid); end
  endtask

  task automatic test_busy_start();
    int n_starts, n_res, last_res;
    logic prev_s, prev_v;
    logic [W-1:0] v;
    v = W'($urandom_range(0, 1023));
    vin = v;
    n_starts = 0; n_res = 0; last_res = -1;
    prev_s = SAMPLE; prev_v = data_valid;
    data_ready = 1'b1;
    start = 1'b1;
    for (int k = 0; k < 4 * PERIOD; k++) begin
      tick();
      if (SAMPLE && !prev_s) n_starts++;
      if (data_valid && !prev_v) begin
        checks++;
        if (n_res == 0 && k != LAT) begin
          errors++; $display("FAIL b2b_first_result: got cycle %0d expected %0d", k, LAT);
        end else if (n_res > 0 && k - last_res != PERIOD) begin
          errors++; $display("FAIL b2b_interval: got %0d expected %0d", k - last_res, PERIOD);
        end
        checks++;
        if (data !== v) begin errors++; $display("FAIL b2b_data: got %h expected %h", data, v); end
        last_res = k;
        n_res++;
      end
      prev_s = SAMPLE;
      prev_v = data_valid;
    end
    start = 1'b0;
    tick(); tick();
    data_ready = 1'b0;
    checks++; if (n_starts != 4) begin errors++; $display("FAIL b2b_starts: got %0d expected 4", n_starts); end
    checks++; if (n_res != 4) begin errors++; $display("FAIL b2b_results: got %0d expected 4", n_res); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
  endtask

  task automatic test_reset_mid();
    int sh, lat;
    vin = W'($urandom_range(1, 1023));
    capture(-1, sh, lat);
    start = 1'b1;
    tick();
    start = 1'b0;
    // Eight cycles after the start edge the search is working on bit 5.
    for (int i = 0; i < SC + (W - 1 - 5); i++) tick();
    checks++; if (busy !== 1'b1 || SAMPLE !== 1'b0) begin
      errors++; $display("FAIL mid_in_convert: got busy %b sample %b expected 1 0", busy, SAMPLE);
    end
    reset = 1'b1;
    #1;
    checks++; if (SAMPLE !== 1'b0 || busy !== 1'b0 || DAC_D !== '0) begin
      errors++; $display("FAIL mid_reset_ctrl: got sample %b busy %b dac %h expected 0 0 000", SAMPLE, busy, DAC_D);
    end
    checks++; if (data !== '0 || data_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL mid_reset_result: got data %h valid %b ovr %b expected 000 0 0", data, data_valid, overrun);
    end
    tick();
    reset = 1'b0;
    tick();
    vin = 10'h3C1;
    model(vin, 0);
    capture(-1, sh, lat);
    checks++; if (data !== 10'h3C1) begin errors++; $display("FAIL mid_after_data: got %h expected 3c1", data); end
    checks++; if (lat != LAT) begin errors++; $display("FAIL mid_after_latency: got %0d expected %0d", lat, LAT); end
    consume();
  endtask

  task automatic test_random();
    int sh, lat, bad;
    logic [W-1:0] v;
    for (int n = 0; n < 8; n++) begin
      v = W'($urandom_range(0, 1023));
      vin = v;
      model(v, 0);
      capture(-1, sh, lat);
      bad = 0;
      for (int i = 0; i < W; i++) if (obs_dac[i] !== exp_trial[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand_trials[%0d]: got %0d wrong codes expected 0 (vin %h)", n, bad, v); end
      checks++; if (data !== exp_res) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", n, data, exp_res); end
      checks++; if (lat != LAT) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", n, lat, LAT); end
      if ($urandom_range(0, 1) == 1) consume();
      else begin
        tick();
        consume();
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_extremes();
    test_consume();
    test_overrun();
    test_busy_start();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Digital successive-approximation controller for an external analog comparator and a 10-bit DAC. It is the analog-to-digital counterpart of the SoC's 10-bit digital-to-analog output path. On each `start` it:
- tracks and holds the input,
- binary-searches the code by driving trial codes onto `DAC_D` and sampling `COMP`,
- hands the result to the core through a valid/ready interface.

It runs in the PLL-generated `CLK` domain alongside `rvmyth`.

## Interface
- `WIDTH`, default 10: conversion resolution, equal to the DAC width.
- `SAMPLE_CYCLES`, default 4: track/hold duration in `CLK` cycles; must be at least 1.

Ports:
- `CLK`  input  1  system clock from `avsdpll`; all logic is on its rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  conversion request; sampled only in IDLE.
- `COMP`  input  1  comparator output; 1 means Vin ≥ V(`DAC_D`); already synchronous to `CLK`.
- `SAMPLE`  output  1  track/hold control; 1 means tracking.
- `DAC_D`  output  WIDTH  trial code driven to the DAC.
- `busy`  output  1  high in SAMPLE and CONVERT.
- `data`  output  WIDTH  last conversion result.
- `data_valid`  output  1  result available.
- `data_ready`  input  1  consumer accepts `data`.
- `overrun`  output  1  sticky flag: a result was lost.

## Operation
- **Reset values:**
  - state IDLE;
  - `SAMPLE`=0, `DAC_D`=0, `busy`=0, `data`=0, `data_valid`=0, `overrun`=0;
  - bit index = WIDTH-1, sample counter = 0.
- **FSM states:** IDLE, SAMPLE, CONVERT.
- **IDLE:**
  - On `start`=1, go to SAMPLE; `SAMPLE`=1, counter=0.
  - `DAC_D` holds 0.
- **SAMPLE:**
  - Counter increments each cycle.
  - When counter = SAMPLE_CYCLES-1, go to CONVERT with `SAMPLE`=0, bit index = WIDTH-1, `DAC_D` = 1<<(WIDTH-1).
- **CONVERT, each cycle:**
  - If `COMP`=1, bit[idx] of `DAC_D` is kept; otherwise it is cleared.
  - If idx>0, set bit[idx-1] and decrement idx.
  - If idx=0, finish:
    - load `data` with the decided code and set `data_valid`;
    - `DAC_D` returns to 0 and the state returns to IDLE.
- **Output handshake:**
  - `data_valid` stays high and `data` stays stable until a cycle with `data_valid`=1 and `data_ready`=1; `data_valid` clears on the next edge.
- **New result while valid:**
  - If a result completes while `data_valid`=1 and `data_ready`=0, the new result overwrites `data` and `overrun` is set.
  - If `data_ready`=1 in that same cycle, no overrun; the new result loads and `data_valid` stays 1.
- **`start` handling:**
  - `start` while busy is ignored; no queuing.
  - `start` in IDLE with a pending result is allowed.
- **`overrun`** is cleared only by `reset`.
- **Reset mid-conversion:** all outputs return to their reset values asynchronously; the partial result is discarded.

## Timing
- `start` sampled high at edge E0: `SAMPLE`=1 for cycles E0..E0+SAMPLE_CYCLES.
- First trial code appears after edge E0+SAMPLE_CYCLES.
- One bit is decided per cycle.
- `data_valid` rises after edge E0+SAMPLE_CYCLES+WIDTH, which is 14 cycles with the defaults.
- `COMP` is sampled on the edge ending the cycle in which the corresponding trial code is driven. Analog DAC/comparator settling must fit within one `CLK` period.
- Back-to-back throughput: one conversion per SAMPLE_CYCLES+WIDTH+1 cycles, because `start` is only re-sampled in IDLE.

## Structure
- Package `sar_adc_pkg`:
  - state enum (IDLE, SAMPLE, CONVERT);
  - default WIDTH and SAMPLE_CYCLES constants.
- Sub-module `sar_register`:
  - trial-code/bit-index datapath with inputs init, step, COMP;
  - outputs code and last-bit flag.
- Top `sar_adc_ctrl` holds:
  - the FSM;
  - the sample counter;
  - the output register and handshake;
  - overrun logic.
- Instantiated in the SoC top, driving a second DAC instance and connected to the core.

## Test plan
- **Basic conversion:** comparator model with Vin code 0x2A5, pulse `start`.
  - `DAC_D` sequence 0x200, 0x300, 0x280, 0x2C0, 0x2A0, 0x2B0, 0x2A8, 0x2A4, 0x2A6, 0x2A5.
  - `data`=0x2A5 with `data_valid` 14 cycles after `start`.
- **Extremes:** `COMP` tied 1 gives `data`=0x3FF; `COMP` tied 0 gives `data`=0x000. `SAMPLE` is high for exactly 4 cycles in each case.
- **Handshake hold and overrun:**
  - Hold `data_ready`=0 and complete two conversions (0x155, then 0x0AA): `data`=0x0AA, `overrun`=1.
  - Repeat with `data_ready`=1 on the completion cycle: `overrun`=0.
- **`start` while busy:** assert `start` every cycle during a conversion. Exactly one result is produced per SAMPLE_CYCLES+WIDTH+1 cycles, and no conversion restarts mid-flight.
- **Reset mid-conversion:** assert `reset` during CONVERT at bit 5. All outputs are at reset values immediately. A subsequent `start` with Vin 0x3C1 yields 0x3C1.
- **Consume timing:** `data_ready` asserted 3 cycles after `data_valid`. `data_valid` drops on the edge after the handshake, and `data` is unchanged until then.
